alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 Parameter DATA_W, default 8, operand width; power of two, minimum 4.
REQ-002 Parameter CMD_W, default 4, command width.
REQ-003 Parameter TIMEOUT, default 16, cycles to wait for a missing operand; range 1..255.
REQ-004 CLK  in  1  clock; all logic on the rising edge.
REQ-005 RST  in  1  reset; synchronous, active-high.
REQ-006 CE  in  1  clock enable; when low, all state, counters and pipeline registers hold.
REQ-007 MODE  in  1  1 = arithmetic command set, 0 = logic command set.
REQ-008 CMD  in  CMD_W  operation code.
REQ-009 INP_VALID  in  2  bit0 = OPA valid, bit1 = OPB valid.
REQ-010 OPA, OPB  in  DATA_W each  operands.
REQ-011 CIN  in  1  carry/borrow in; sampled with the operand that completes the pair.
REQ-012 RES  out  2*DATA_W  result; zero-extended unless stated otherwise.
REQ-013 RES_VALID  out  1  one-cycle pulse qualifying all result outputs.
REQ-014 COUT, OFLOW, G, E, L, ERR  out  1 each  status flags; valid only while RES_VALID=1, otherwise 0.
REQ-015 BUSY  out  1  high in WAIT_A, WAIT_B and EXEC.

Function
REQ-016 FSM states: IDLE, WAIT_A, WAIT_B, EXEC.
REQ-017 IDLE transitions: INP_VALID=11 captures OPA, OPB, CMD, MODE and goes to EXEC; 01 captures OPA, CMD, MODE and goes to WAIT_B; 10 captures OPB, CMD, MODE and goes to WAIT_A; 00 stays in IDLE.
REQ-018 WAIT_B: INP_VALID bit1 captures OPB and goes to EXEC; CMD and MODE stay as captured with the first operand.
REQ-019 WAIT_A is symmetric to WAIT_B.
REQ-020 In WAIT_A/WAIT_B with INP_VALID=11: both operands and CMD are recaptured, then go to EXEC.
REQ-021 A wait counter clears on entry to WAIT_x and increments on each CE cycle without the missing operand.
REQ-022 Timeout: when the counter reaches TIMEOUT, assert RES_VALID=1, ERR=1, RES=0 on that edge and return to IDLE.
REQ-023 Operand arrival on the same edge the counter reaches TIMEOUT: the operand wins; no error.
REQ-024 EXEC latency: result registered one cycle after the completing capture edge; multiply commands take two cycles.
REQ-025 EXEC returns to IDLE on the RES_VALID edge; inputs are ignored while in EXEC.
REQ-026 Arithmetic command set (MODE=1):
- 0 ADD: RES = A+B, RES[DATA_W] = COUT.
- 1 SUB: RES = A-B (DATA_W bits); OFLOW = (A<B).
- 2 ADD_CIN: A+B+CIN, flags as ADD.
- 3 SUB_CIN: A-B-CIN; OFLOW = (A < B+CIN).
- 4 INC_A; 5 DEC_A; 6 INC_B; 7 DEC_B: DATA_W-bit wrap, COUT/OFLOW = carry/borrow out.
- 8 CMP: RES = 0; exactly one of G/E/L set, unsigned.
- 9 MUL1: (A+1)*(B+1), full 2*DATA_W product, mod 2^(2*DATA_W).
- 10 MULSH: (A<<1 within DATA_W+1 bits)*B, truncated to 2*DATA_W.
REQ-027 Logic command set (MODE=0), all DATA_W-bit results:
- 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR, 6 NOT_A, 7 NOT_B.
- 8 SHR1_A, 9 SHL1_A, 10 SHR1_B, 11 SHL1_B.
- 12 ROL_A_B, 13 ROR_A_B: rotate A by B[log2(DATA_W)-1:0].
- For 12/13, ERR=1 if any higher bit of B is set; RES is still the rotated value.
REQ-028 Unlisted CMD in either mode: RES=0, ERR=1, RES_VALID=1 at normal latency.

Reset
REQ-029 RST has priority over CE.
REQ-030 On RST: FSM to IDLE; counter, captured operands and pipeline registers to 0; RES=0; all flags, RES_VALID and BUSY to 0.
REQ-031 RST during WAIT_x or EXEC discards the pending operation; no RES_VALID is produced for it.

Configuration
REQ-032 Macro ALU_PIPE_MUL_EN defined: arithmetic CMD 9/10 implemented with a two-stage multiplier and two-cycle latency.
REQ-033 Macro ALU_PIPE_MUL_EN undefined: no multiplier is synthesised; CMD 9/10 behave per REQ-028 with one-cycle latency.

Verification
REQ-034 MODE=1, CMD=0, OPA=0xFF, OPB=0x01, INP_VALID=11 -> next cycle RES=0x0100, COUT=1, RES_VALID=1.
REQ-035 MUL_EN defined, MODE=1, CMD=9, OPA=OPB=0x0F, INP_VALID=11 -> two cycles later RES=0x0100, RES_VALID=1; undefined -> ERR=1 after one cycle.
REQ-036 INP_VALID=01 with OPA=0x10, then 00 for 16 cycles -> on the 16th edge ERR=1, RES=0, RES_VALID=1, BUSY=0; 15 cycles then 10 -> normal result, ERR=0.
REQ-037 MODE=0, CMD=12, OPA=0x81, OPB=0x01 -> RES=0x03, ERR=0; OPB=0x11 -> RES=0x03, ERR=1.
REQ-038 MODE=1, CMD=8, OPA=5, OPB=9 -> L=1, G=0, E=0, RES=0.
REQ-039 INP_VALID=01, RST pulsed in WAIT_B, then OPB supplied -> no RES_VALID; CE=0 for 3 cycles mid-WAIT -> counter frozen, timeout delayed by 3 cycles.

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe: two-operand FSM-sequenced ALU with operand wait/timeout and registered status flags.
// Define ALU_PIPE_MUL_EN to build the two-stage multiplier for arithmetic commands 9/10.
module alu_pipe #(
   parameter int DATA_W  = 8,
   parameter int CMD_W   = 4,
   parameter int TIMEOUT = 16
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic                CE,
   input  logic                MODE,
   input  logic [CMD_W-1:0]    CMD,
   input  logic [1:0]          INP_VALID,
   input  logic [DATA_W-1:0]   OPA,
   input  logic [DATA_W-1:0]   OPB,
   input  logic                CIN,
   output logic [2*DATA_W-1:0] RES,
   output logic                RES_VALID,
   output logic                COUT,
   output logic                OFLOW,
   output logic                G,
   output logic                E,
   output logic                L,
   output logic                ERR,
   output logic                BUSY
);
   localparam int W = DATA_W;
   localparam int W2 = 2 * DATA_W;
   localparam int LW = $clog2(DATA_W);
   localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
   localparam logic [W:0] ONE = 1;
   typedef enum logic [1:0] {IDLE, WAIT_A, WAIT_B, EXEC} state_t;
   state_t state;
   logic [W-1:0] a, b;
   logic [CMD_W-1:0] cmd;
   logic mode, cin, miss;
   logic [7:0] cnt;
   logic [W:0] ext, t;
   logic [W2-1:0] dbl;
   logic c_o, o_o, g_o, e_o, l_o, err_o;
   int op;
   assign op = int'(cmd);
   assign miss = state == WAIT_A ? INP_VALID[0] : INP_VALID[1];
   assign BUSY = state != IDLE;
`ifdef ALU_PIPE_MUL_EN
   localparam int H = W / 2;
   logic mul_st, is_mul;
   logic [W:0] x, y;
   logic [W2-1:0] pl, ph;
   assign is_mul = mode && (op == 9 || op == 10);
   assign x = op == 9 ? {1'b0, a} + ONE : {a, 1'b0};
   assign y = op == 9 ? {1'b0, b} + ONE : {1'b0, b};
`endif
   always_comb begin
      ext = '0;
      t = '0;
      dbl = '0;
      c_o = 1'b0;
      o_o = 1'b0;
      g_o = 1'b0;
      e_o = 1'b0;
      l_o = 1'b0;
      err_o = 1'b0;
      if (mode) begin
         case (op)
            0: begin ext = {1'b0, a} + {1'b0, b}; c_o = ext[W]; end
            1: begin ext = {1'b0, a - b}; o_o = a < b; end
            2: begin ext = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin}; c_o = ext[W]; end
            3: begin ext = {1'b0, a - b - {{(W-1){1'b0}}, cin}}; o_o = {1'b0, a} < {1'b0, b} + {{W{1'b0}}, cin}; end
            4: begin t = {1'b0, a} + ONE; c_o = t[W]; ext = {1'b0, t[W-1:0]}; end
            5: begin t = {1'b0, a} - ONE; o_o = t[W]; ext = {1'b0, t[W-1:0]}; end
            6: begin t = {1'b0, b} + ONE; c_o = t[W]; ext = {1'b0, t[W-1:0]}; end
            7: begin t = {1'b0, b} - ONE; o_o = t[W]; ext = {1'b0, t[W-1:0]}; end
            8: begin g_o = a > b; e_o = a == b; l_o = a < b; end
            default: err_o = 1'b1;
         endcase
      end else begin
         case (op)
            0: ext = {1'b0, a & b};
            1: ext = {1'b0, ~(a & b)};
            2: ext = {1'b0, a | b};
            3: ext = {1'b0, ~(a | b)};
            4: ext = {1'b0, a ^ b};
            5: ext = {1'b0, ~(a ^ b)};
            6: ext = {1'b0, ~a};
            7: ext = {1'b0, ~b};
            8: ext = {1'b0, a >> 1};
            9: ext = {1'b0, a << 1};
            10: ext = {1'b0, b >> 1};
            11: ext = {1'b0, b << 1};
            12: begin dbl = {a, a} << b[LW-1:0]; ext = {1'b0, dbl[W2-1:W]}; err_o = |(b >> LW); end
            13: begin dbl = {a, a} >> b[LW-1:0]; ext = {1'b0, dbl[W-1:0]}; err_o = |(b >> LW); end
            default: err_o = 1'b1;
         endcase
      end
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         a <= '0;
         b <= '0;
         cmd <= '0;
         mode <= 1'b0;
         cin <= 1'b0;
         cnt <= '0;
         RES <= '0;
         RES_VALID <= 1'b0;
         {COUT, OFLOW, G, E, L, ERR} <= '0;
`ifdef ALU_PIPE_MUL_EN
         mul_st <= 1'b0;
         pl <= '0;
         ph <= '0;
`endif
      end else if (CE) begin
         RES <= '0;
         RES_VALID <= 1'b0;
         {COUT, OFLOW, G, E, L, ERR} <= '0;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (INP_VALID[0]) a <= OPA;
               if (INP_VALID[1]) b <= OPB;
               if (|INP_VALID) begin
                  cmd <= CMD;
                  mode <= MODE;
                  cin <= CIN;
               end
               state <= INP_VALID == 2'b11 ? EXEC : INP_VALID[0] ? WAIT_B : INP_VALID[1] ? WAIT_A : IDLE;
            end
            WAIT_A, WAIT_B: begin
               if (INP_VALID == 2'b11) begin
                  a <= OPA;
                  b <= OPB;
                  cmd <= CMD;
                  cin <= CIN;
                  state <= EXEC;
               end else if (miss) begin
                  if (state == WAIT_A) a <= OPA;
                  else b <= OPB;
                  cin <= CIN;
                  state <= EXEC;
               end else if (cnt == LAST) begin
                  RES_VALID <= 1'b1;
                  ERR <= 1'b1;
                  state <= IDLE;
               end else cnt <= cnt + 8'd1;
            end
            EXEC: begin
`ifdef ALU_PIPE_MUL_EN
               // first cycle forms partial products on the low/high halves of y
               if (is_mul && !mul_st) begin
                  pl <= W2'(x) * W2'(y[H-1:0]);
                  ph <= W2'(x) * W2'(y[W:H]);
                  mul_st <= 1'b1;
               end else if (is_mul) begin
                  RES <= pl + (ph << H);
                  RES_VALID <= 1'b1;
                  mul_st <= 1'b0;
                  state <= IDLE;
               end else
`endif
               begin
                  RES <= W2'(ext);
                  RES_VALID <= 1'b1;
                  {COUT, OFLOW, G, E, L, ERR} <= {c_o, o_o, g_o, e_o, l_o, err_o};
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed vectors with a queue-based scoreboard and an independent result monitor.
module tb_alu_pipe;
   typedef struct {
      logic [15:0] res;
      logic [5:0]  fl;
      int          cyc;
      int          id;
   } exp_t;
`ifdef ALU_PIPE_MUL_EN
   localparam bit MUL = 1'b1;
`else
   localparam bit MUL = 1'b0;
`endif
   localparam logic [5:0] F_C = 6'b100000, F_O = 6'b010000, F_G = 6'b001000;
   localparam logic [5:0] F_E = 6'b000100, F_L = 6'b000010, F_ERR = 6'b000001;
   logic CLK = 0, RST = 1, CE = 1, MODE = 0, CIN = 0;
   logic [3:0] CMD = 0;
   logic [1:0] INP_VALID = 0;
   logic [7:0] OPA = 0, OPB = 0;
   logic [15:0] RES;
   logic RES_VALID, COUT, OFLOW, G, E, L, ERR, BUSY;
   int cyc = 0, compared = 0, mismatched = 0, next_id = 0;
   bit started = 0;
   exp_t q[$];

   alu_pipe #(.DATA_W(8), .CMD_W(4), .TIMEOUT(16)) dut (
      .CLK(CLK), .RST(RST), .CE(CE), .MODE(MODE), .CMD(CMD), .INP_VALID(INP_VALID),
      .OPA(OPA), .OPB(OPB), .CIN(CIN), .RES(RES), .RES_VALID(RES_VALID), .COUT(COUT),
      .OFLOW(OFLOW), .G(G), .E(E), .L(L), .ERR(ERR), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   always @(negedge CLK) begin
      exp_t x;
      if (started) begin
         if (RES_VALID) begin
            compared++;
            if (q.size() == 0) begin
               mismatched++;
               $display("FAIL unexpected_valid: got res=%h flags=%b at cyc %0d, want no result", RES, {COUT, OFLOW, G, E, L, ERR}, cyc);
            end else begin
               x = q.pop_front();
               if ({RES, COUT, OFLOW, G, E, L, ERR} !== {x.res, x.fl} || cyc != x.cyc) begin
                  mismatched++;
                  $display("FAIL result#%0d: got res=%h flags=%b cyc=%0d, want res=%h flags=%b cyc=%0d", x.id, RES, {COUT, OFLOW, G, E, L, ERR}, cyc, x.res, x.fl, x.cyc);
               end
            end
         end else if ({COUT, OFLOW, G, E, L, ERR} !== 6'b0) begin
            compared++;
            mismatched++;
            $display("FAIL idle_flags: got %b, want 000000 at cyc %0d", {COUT, OFLOW, G, E, L, ERR}, cyc);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      compared++;
      if (act !== want) begin
         mismatched++;
         $display("FAIL %s: got %h, want %h", name, act, want);
      end
   endtask

   task automatic issue(input logic [1:0] v, input logic [7:0] a, input logic [7:0] b, input logic [3:0] c, input logic m, input logic ci, output int cap);
      INP_VALID = v; OPA = a; OPB = b; CMD = c; MODE = m; CIN = ci;
      @(posedge CLK);
      #1;
      cap = cyc;
      INP_VALID = 0;
   endtask

   task automatic expect_res(input logic [15:0] r, input logic [5:0] f, input int at);
      exp_t x;
      x.res = r; x.fl = f; x.cyc = at; x.id = next_id++;
      q.push_back(x);
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (q.size() != 0 && n < 40) begin
         @(negedge CLK);
         n++;
      end
      if (q.size() != 0) begin
         compared++;
         mismatched++;
         $display("FAIL %s: got no result within 40 cycles, want %0d pending results", name, q.size());
         q.delete();
      end
      @(negedge CLK);
   endtask

   task automatic op(input string name, input logic m, input logic [3:0] c, input logic [7:0] a, input logic [7:0] b, input logic ci, input logic [15:0] r, input logic [5:0] f, input int lat);
      int cap;
      issue(2'b11, a, b, c, m, ci, cap);
      expect_res(r, f, cap + lat);
      drain(name);
   endtask

   initial begin
      int cap;
      repeat (3) @(posedge CLK);
      #1 RST = 0;
      started = 1;
      chk("reset_res", 32'(RES), 0);
      chk("reset_valid", 32'(RES_VALID), 0);
      chk("reset_busy", 32'(BUSY), 0);
      @(negedge CLK);
      op("add", 1, 0, 8'hFF, 8'h01, 0, 16'h0100, F_C, 1);
      op("sub", 1, 1, 8'h05, 8'h09, 0, 16'h00FC, F_O, 1);
      op("add_cin", 1, 2, 8'h7F, 8'h80, 1, 16'h0100, F_C, 1);
      op("sub_cin_eq", 1, 3, 8'h10, 8'h0F, 1, 16'h0000, 0, 1);
      op("sub_cin_lt", 1, 3, 8'h10, 8'h10, 1, 16'h00FF, F_O, 1);
      op("inc_a", 1, 4, 8'hFF, 8'h00, 0, 16'h0000, F_C, 1);
      op("dec_a", 1, 5, 8'h00, 8'h44, 0, 16'h00FF, F_O, 1);
      op("inc_b", 1, 6, 8'h12, 8'h34, 0, 16'h0035, 0, 1);
      op("dec_b", 1, 7, 8'h12, 8'h00, 0, 16'h00FF, F_O, 1);
      op("cmp_lt", 1, 8, 8'h05, 8'h09, 0, 16'h0000, F_L, 1);
      op("cmp_eq", 1, 8, 8'h09, 8'h09, 0, 16'h0000, F_E, 1);
      op("cmp_gt", 1, 8, 8'h0A, 8'h09, 0, 16'h0000, F_G, 1);
      op("mul1", 1, 9, 8'h0F, 8'h0F, 0, MUL ? 16'h0100 : 16'h0000, MUL ? 6'b0 : F_ERR, MUL ? 2 : 1);
      op("mul1_wrap", 1, 9, 8'hFF, 8'hFF, 0, 16'h0000, MUL ? 6'b0 : F_ERR, MUL ? 2 : 1);
      op("mulsh", 1, 10, 8'h81, 8'h03, 0, MUL ? 16'h0306 : 16'h0000, MUL ? 6'b0 : F_ERR, MUL ? 2 : 1);
      op("mulsh_big", 1, 10, 8'h80, 8'hFF, 0, MUL ? 16'hFF00 : 16'h0000, MUL ? 6'b0 : F_ERR, MUL ? 2 : 1);
      op("arith_bad", 1, 11, 8'h12, 8'h34, 0, 16'h0000, F_ERR, 1);
      op("and", 0, 0, 8'hF0, 8'h3C, 0, 16'h0030, 0, 1);
      op("nand", 0, 1, 8'hF0, 8'h3C, 0, 16'h00CF, 0, 1);
      op("nor", 0, 3, 8'hF0, 8'h3C, 0, 16'h0003, 0, 1);
      op("xnor", 0, 5, 8'hF0, 8'h3C, 0, 16'h0033, 0, 1);
      op("shl1_a", 0, 9, 8'h81, 8'h00, 0, 16'h0002, 0, 1);
      op("shr1_b", 0, 10, 8'h00, 8'h3C, 0, 16'h001E, 0, 1);
      op("rol", 0, 12, 8'h81, 8'h01, 0, 16'h0003, 0, 1);
      op("rol_err", 0, 12, 8'h81, 8'h11, 0, 16'h0003, F_ERR, 1);
      op("ror", 0, 13, 8'h81, 8'h01, 0, 16'h00C0, 0, 1);
      op("logic_bad", 0, 15, 8'h81, 8'h01, 0, 16'h0000, F_ERR, 1);
      // B arrives on the last cycle before timeout, with CIN taken from that edge
      issue(2'b01, 8'h10, 8'h00, 3, 1, 0, cap);
      chk("busy_wait", 32'(BUSY), 1);
      repeat (15) @(posedge CLK);
      #1;
      issue(2'b10, 8'h00, 8'h05, 0, 0, 1, cap);
      expect_res(16'h000A, 0, cap + 1);
      drain("late_b");
      issue(2'b01, 8'h10, 8'h00, 0, 1, 0, cap);
      expect_res(16'h0000, F_ERR, cap + 16);
      drain("timeout");
      chk("busy_after_timeout", 32'(BUSY), 0);
      issue(2'b01, 8'h01, 8'h00, 0, 1, 0, cap);
      issue(2'b11, 8'h02, 8'h03, 1, 1, 0, cap);
      expect_res(16'h00FF, F_O, cap + 1);
      drain("recapture");
      issue(2'b10, 8'h00, 8'h20, 4, 0, 0, cap);
      issue(2'b01, 8'h0F, 8'h00, 0, 0, 0, cap);
      expect_res(16'h002F, 0, cap + 1);
      drain("wait_a");
      issue(2'b01, 8'h10, 8'h00, 0, 1, 0, cap);
      RST = 1;
      @(posedge CLK);
      #1 RST = 0;
      chk("busy_after_rst", 32'(BUSY), 0);
      issue(2'b10, 8'h00, 8'h05, 0, 1, 0, cap);
      expect_res(16'h0000, F_ERR, cap + 16);
      drain("rst_discard");
      issue(2'b01, 8'h10, 8'h00, 0, 1, 0, cap);
      expect_res(16'h0000, F_ERR, cap + 19);
      repeat (5) @(posedge CLK);
      #1 CE = 0;
      repeat (3) @(posedge CLK);
      #1 CE = 1;
      drain("ce_freeze");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no completion by 100000, want finish");
      $fatal(1);
   end
endmodule
